apu_noise_gen: RTL and testbench
================================

APU_NOISE_GEN -- requirements
Module: apu_noise_gen

Interface
REQ-001 SHALL have parameter LFSR_BITS, default 15, meaning shift-register width; legal range 8..24.
REQ-002 SHALL have parameter OUT_BITS, default 4, meaning output sample width; legal range 4..8.
REQ-003 SHALL have port clk_in, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, meaning reset, synchronous and active-high.
REQ-005 SHALL have port en_in, input, 1, meaning channel enable ($4015 bit).
REQ-006 SHALL have port apu_cycle_pulse_in, input, 1, meaning a 1-clk pulse per APU cycle.
REQ-007 SHALL have port lc_pulse_in, input, 1, meaning a 1-clk length-counter tick.
REQ-008 SHALL have port eg_pulse_in, input, 1, meaning a 1-clk envelope tick.
REQ-009 SHALL have port a_in, input, 2, meaning register index 0..3.
REQ-010 SHALL have port d_in, input, 8, meaning write data.
REQ-011 SHALL have port wr_in, input, 1, meaning register write strobe.
REQ-012 SHALL have port pal_in, input, 1, meaning period-table select: 0 NTSC, 1 PAL.
REQ-013 SHALL have port noise_out, output, OUT_BITS, meaning channel sample.
REQ-014 SHALL have port active_out, output, 1, meaning length counter nonzero.

Function
REQ-015 Reg0 write SHALL latch halt/loop=d[5], constvol=d[4], vol=d[3:0]; reg2 write SHALL latch mode=d[7], pidx=d[3:0].
REQ-016 Reg1 write SHALL, when d[0]=1, reseed LFSR to 1 next clk; d[7:1] ignored.
REQ-017 Reg3 write SHALL set envelope start flag and, if en_in=1, load length counter with LEN[d[7:3]].
REQ-018 LEN table (index 0..31) SHALL be 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
REQ-019 Period P (APU cycles) SHALL be NTSC 2,4,8,16,32,48,64,80,101,127,190,254,381,508,1017,2034 or PAL 2,4,7,15,30,44,59,74,94,118,177,236,354,472,945,1889, indexed by pidx, pal_in sampled at each reload.
REQ-020 Timer: 12-bit down counter, decrements on apu_cycle_pulse_in; on pulse while 0 SHALL reload P-1 and emit one LFSR step that same clk; LFSR step interval is exactly P pulses.
REQ-021 Reg2 write SHALL NOT reset the timer; new P takes effect at next reload.
REQ-022 LFSR step: fb = lfsr[0] XOR (mode ? lfsr[6] : lfsr[1]); lfsr <= {fb, lfsr[LFSR_BITS-1:1]}.
REQ-023 If LFSR equals zero at any clk it SHALL be forced to 1 on the next clk (lockup recovery); reseed (REQ-016) wins over a same-clk step.
REQ-024 Envelope on eg_pulse_in: if start flag, clear it, decay=15, divider=vol; else if divider=0, divider=vol and decay decrements if >0, else becomes 15 when loop=1; else divider decrements.
REQ-025 Length counter (8-bit) on lc_pulse_in SHALL decrement if nonzero and halt=0; reg3 load same clk wins over decrement.
REQ-026 en_in=0 SHALL clear length counter next clk and block loads while low.
REQ-027 vol4 = constvol ? vol : decay; noise_out SHALL be (lfsr[0]=0 and length>0) ? vol4 << (OUT_BITS-4) : 0, combinational from registers.
REQ-028 active_out SHALL be (length counter != 0).
REQ-029 Writes with wr_in=0 SHALL have no effect; all strobes single-clk, no handshake.

Reset
REQ-030 rst_in=1 SHALL set lfsr=1, mode=0, pidx=0, timer=0, length=0, decay=0, divider=0, start=0, halt=0, constvol=0, vol=0.
REQ-031 During reset noise_out=0 and active_out=0; reset mid-operation SHALL discard pending start and timer state.

Verification
REQ-032 Reset, en_in=1, write reg0=0x1F, reg2=0x00, reg3=0x08 -> active_out=1, length=254, noise_out toggles 0/15 (OUT_BITS=4) per LFSR bit 0, LFSR step every 2 APU pulses.
REQ-033 reg2=0x0F, pal_in=0 then 1 -> steps spaced 2034 then (after next reload) 1889 APU pulses.
REQ-034 mode=0 from lfsr=1, LFSR_BITS=15 -> sequence period 32767 steps; mode=1 -> period 93 steps.
REQ-035 halt=0, length=2, two lc pulses -> active_out falls after second; en_in=0 -> length 0 next clk, reg3 write ignored.
REQ-036 reg0=0x21 (loop, vol=1), reg3 write, eg pulses -> decay 15, then decrements every 2 eg pulses to 0, then wraps to 15.
REQ-037 Reg1 write 0x01 coincident with timer step -> lfsr=1 next clk; forced-zero LFSR -> 1 next clk.

Source files
------------

// File: rtl/apu_noise_gen.sv
// NES-style noise channel: LFSR noise source clocked by a period-table timer,
// gated by a length counter and scaled by a constant volume or a decaying envelope.
module apu_noise_gen #(
   parameter int LFSR_BITS = 15,
   parameter int OUT_BITS  = 4
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                en_in,
   input  logic                apu_cycle_pulse_in,
   input  logic                lc_pulse_in,
   input  logic                eg_pulse_in,
   input  logic [1:0]          a_in,
   input  logic [7:0]          d_in,
   input  logic                wr_in,
   input  logic                pal_in,
   output logic [OUT_BITS-1:0] noise_out,
   output logic                active_out
);

   logic [LFSR_BITS-1:0] lfsr;
   logic                 mode;
   logic [3:0]           pidx;
   logic [11:0]          timer;
   logic [7:0]           len_cnt;
   logic [3:0]           decay;
   logic [3:0]           divider;
   logic                 start;
   logic                 halt;
   logic                 constvol;
   logic [3:0]           vol;

   logic                 wr0, wr1, wr2, wr3;
   logic                 step;
   logic                 fb;
   logic [3:0]           vol4;
   logic                 unused_bits;

   function automatic logic [7:0] len_lut(input logic [4:0] idx);
      case (idx)
         5'd0:  len_lut = 8'd10;   5'd1:  len_lut = 8'd254;
         5'd2:  len_lut = 8'd20;   5'd3:  len_lut = 8'd2;
         5'd4:  len_lut = 8'd40;   5'd5:  len_lut = 8'd4;
         5'd6:  len_lut = 8'd80;   5'd7:  len_lut = 8'd6;
         5'd8:  len_lut = 8'd160;  5'd9:  len_lut = 8'd8;
         5'd10: len_lut = 8'd60;   5'd11: len_lut = 8'd10;
         5'd12: len_lut = 8'd14;   5'd13: len_lut = 8'd12;
         5'd14: len_lut = 8'd26;   5'd15: len_lut = 8'd14;
         5'd16: len_lut = 8'd12;   5'd17: len_lut = 8'd16;
         5'd18: len_lut = 8'd24;   5'd19: len_lut = 8'd18;
         5'd20: len_lut = 8'd48;   5'd21: len_lut = 8'd20;
         5'd22: len_lut = 8'd96;   5'd23: len_lut = 8'd22;
         5'd24: len_lut = 8'd192;  5'd25: len_lut = 8'd24;
         5'd26: len_lut = 8'd72;   5'd27: len_lut = 8'd26;
         5'd28: len_lut = 8'd16;   5'd29: len_lut = 8'd28;
         5'd30: len_lut = 8'd32;   default: len_lut = 8'd30;
      endcase
   endfunction

   // Step interval in APU cycles; the timer reloads with this value minus one.
   function automatic logic [11:0] period_lut(input logic [3:0] idx, input logic pal);
      if (!pal) begin
         case (idx)
            4'd0:  period_lut = 12'd2;    4'd1:  period_lut = 12'd4;
            4'd2:  period_lut = 12'd8;    4'd3:  period_lut = 12'd16;
            4'd4:  period_lut = 12'd32;   4'd5:  period_lut = 12'd48;
            4'd6:  period_lut = 12'd64;   4'd7:  period_lut = 12'd80;
            4'd8:  period_lut = 12'd101;  4'd9:  period_lut = 12'd127;
            4'd10: period_lut = 12'd190;  4'd11: period_lut = 12'd254;
            4'd12: period_lut = 12'd381;  4'd13: period_lut = 12'd508;
            4'd14: period_lut = 12'd1017; default: period_lut = 12'd2034;
         endcase
      end else begin
         case (idx)
            4'd0:  period_lut = 12'd2;    4'd1:  period_lut = 12'd4;
            4'd2:  period_lut = 12'd7;    4'd3:  period_lut = 12'd15;
            4'd4:  period_lut = 12'd30;   4'd5:  period_lut = 12'd44;
            4'd6:  period_lut = 12'd59;   4'd7:  period_lut = 12'd74;
            4'd8:  period_lut = 12'd94;   4'd9:  period_lut = 12'd118;
            4'd10: period_lut = 12'd177;  4'd11: period_lut = 12'd236;
            4'd12: period_lut = 12'd354;  4'd13: period_lut = 12'd472;
            4'd14: period_lut = 12'd945;  default: period_lut = 12'd1889;
         endcase
      end
   endfunction

   assign wr0         = wr_in && (a_in == 2'd0);
   assign wr1         = wr_in && (a_in == 2'd1);
   assign wr2         = wr_in && (a_in == 2'd2);
   assign wr3         = wr_in && (a_in == 2'd3);
   assign step        = apu_cycle_pulse_in && (timer == 12'd0);
   assign fb          = lfsr[0] ^ (mode ? lfsr[6] : lfsr[1]);
   assign unused_bits = d_in[6];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         lfsr     <= LFSR_BITS'(1);
         mode     <= 1'b0;
         pidx     <= 4'd0;
         timer    <= 12'd0;
         len_cnt  <= 8'd0;
         decay    <= 4'd0;
         divider  <= 4'd0;
         start    <= 1'b0;
         halt     <= 1'b0;
         constvol <= 1'b0;
         vol      <= 4'd0;
      end else begin
         // Reseed beats lockup recovery, which beats a normal step.
         if (wr1 && d_in[0])
            lfsr <= LFSR_BITS'(1);
         else if (lfsr == '0)
            lfsr <= LFSR_BITS'(1);
         else if (step)
            lfsr <= {fb, lfsr[LFSR_BITS-1:1]};

         if (apu_cycle_pulse_in) begin
            if (timer == 12'd0)
               timer <= period_lut(pidx, pal_in) - 12'd1;
            else
               timer <= timer - 12'd1;
         end

         if (wr0) begin
            halt     <= d_in[5];
            constvol <= d_in[4];
            vol      <= d_in[3:0];
         end

         if (wr2) begin
            mode <= d_in[7];
            pidx <= d_in[3:0];
         end

         if (!en_in)
            len_cnt <= 8'd0;
         else if (wr3)
            len_cnt <= len_lut(d_in[7:3]);
         else if (lc_pulse_in && !halt && (len_cnt != 8'd0))
            len_cnt <= len_cnt - 8'd1;

         if (eg_pulse_in) begin
            if (start) begin
               start   <= 1'b0;
               decay   <= 4'd15;
               divider <= vol;
            end else if (divider == 4'd0) begin
               divider <= vol;
               if (decay != 4'd0)
                  decay <= decay - 4'd1;
               else if (halt)
                  decay <= 4'd15;
            end else begin
               divider <= divider - 4'd1;
            end
         end
         // A fresh reg3 write re-arms the envelope even on an envelope tick.
         if (wr3)
            start <= 1'b1;
      end
   end

   assign vol4       = constvol ? vol : decay;
   assign noise_out  = (!lfsr[0] && (len_cnt != 8'd0)) ? (OUT_BITS'(vol4) << (OUT_BITS - 4)) : '0;
   assign active_out = (len_cnt != 8'd0);

endmodule

// File: tb/tb_apu_noise_gen.sv
// Directed bench for apu_noise_gen with default parameters (15-bit LFSR, 4-bit output).
module tb_apu_noise_gen;

   logic       clk_in = 1'b0;
   logic       rst_in, en_in, apu_cycle_pulse_in, lc_pulse_in, eg_pulse_in;
   logic [1:0] a_in;
   logic [7:0] d_in;
   logic       wr_in, pal_in;
   logic [3:0] noise_out;
   logic       active_out;

   int n_total = 0;
   int n_pass  = 0;

   apu_noise_gen #(.LFSR_BITS(15), .OUT_BITS(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in),
      .apu_cycle_pulse_in(apu_cycle_pulse_in), .lc_pulse_in(lc_pulse_in),
      .eg_pulse_in(eg_pulse_in), .a_in(a_in), .d_in(d_in), .wr_in(wr_in),
      .pal_in(pal_in), .noise_out(noise_out), .active_out(active_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [14:0] lstep(input logic [14:0] s, input logic md);
      logic f;
      f = s[0] ^ (md ? s[6] : s[1]);
      return {f, s[14:1]};
   endfunction

   task automatic cyc();
      @(posedge clk_in);
      #1;
      apu_cycle_pulse_in = 1'b0;
      lc_pulse_in        = 1'b0;
      eg_pulse_in        = 1'b0;
      wr_in              = 1'b0;
   endtask

   task automatic wreg(input logic [1:0] a, input logic [7:0] d);
      a_in = a; d_in = d; wr_in = 1'b1;
      cyc();
   endtask

   task automatic apu(input int n);
      repeat (n) begin apu_cycle_pulse_in = 1'b1; cyc(); end
   endtask

   task automatic lc(input int n);
      repeat (n) begin lc_pulse_in = 1'b1; cyc(); end
   endtask

   task automatic chk_noise(input string tag, input logic [3:0] exp);
      n_total++;
      assert (noise_out === exp) n_pass++;
      else $error("FAIL %s: noise_out observed %0d, expected %0d", tag, noise_out, exp);
   endtask

   task automatic chk_active(input string tag, input logic exp);
      n_total++;
      assert (active_out === exp) n_pass++;
      else $error("FAIL %s: active_out observed %0d, expected %0d", tag, active_out, exp);
   endtask

   initial begin
      logic [14:0] m;
      logic [3:0]  e;

      rst_in = 1'b1; en_in = 1'b0; apu_cycle_pulse_in = 1'b0; lc_pulse_in = 1'b0;
      eg_pulse_in = 1'b0; a_in = 2'd0; d_in = 8'd0; wr_in = 1'b0; pal_in = 1'b0;

      // Reset
      cyc();
      chk_noise("rst_noise", 4'd0);
      chk_active("rst_active", 1'b0);
      cyc();
      rst_in = 1'b0; en_in = 1'b1;

      // Basic channel, P=2, constant volume 15
      wreg(2'd0, 8'h1F); wreg(2'd2, 8'h00); wreg(2'd3, 8'h08);
      chk_active("len254_active", 1'b1);
      chk_noise("seed_noise", 4'd0);
      apu(1);  chk_noise("step1", 4'd15);
      apu(27); chk_noise("pulse28", 4'd15);
      apu(1);  chk_noise("pulse29_step15", 4'd0);
      apu(1);  chk_noise("pulse30_hold", 4'd0);
      apu(1);  chk_noise("pulse31_step16", 4'd15);

      // Mode 1 short sequence, reseeded; timer is 1 so steps land on even pulses
      wreg(2'd1, 8'h01);
      chk_noise("reseed", 4'd0);
      wreg(2'd2, 8'h80);
      m = 15'd1;
      for (int k = 1; k <= 186; k++) begin
         apu(1);
         if (k % 2 == 0) m = lstep(m, 1'b1);
         chk_noise($sformatf("mode1_k%0d", k), m[0] ? 4'd0 : 4'd15);
      end
      apu(1);
      chk_noise("mode1_wrap_hold", m[0] ? 4'd0 : 4'd15);

      // Reseed coincident with a timer step
      a_in = 2'd1; d_in = 8'h01; wr_in = 1'b1; apu_cycle_pulse_in = 1'b1;
      cyc();
      chk_noise("reseed_wins", 4'd0);
      apu(1); chk_noise("after_reseed_nostep", 4'd0);
      apu(1); chk_noise("after_reseed_step", 4'd15);

      // Long periods: NTSC 2034 then PAL 1889
      wreg(2'd2, 8'h0F);
      apu(2);
      wreg(2'd1, 8'h01);
      chk_noise("ntsc_reseed", 4'd0);
      apu(2033); chk_noise("ntsc_hold2033", 4'd0);
      pal_in = 1'b1;
      apu(1);    chk_noise("ntsc_step2034", 4'd15);
      wreg(2'd1, 8'h01);
      apu(1888); chk_noise("pal_hold1888", 4'd0);
      apu(1);    chk_noise("pal_step1889", 4'd15);

      // Length counter: enable gating, write strobe, load priority, halt, table ends
      en_in = 1'b0; cyc();
      chk_active("en_clear", 1'b0);
      chk_noise("en_clear_noise", 4'd0);
      wreg(2'd3, 8'h08);
      chk_active("en_blocks_load", 1'b0);
      en_in = 1'b1; a_in = 2'd3; d_in = 8'h08; wr_in = 1'b0; cyc();
      chk_active("no_wr_strobe", 1'b0);
      wreg(2'd3, 8'h18);
      chk_active("len2_load", 1'b1);
      chk_noise("len2_noise", 4'd15);
      lc(1); chk_active("len2_lc1", 1'b1);
      lc(1); chk_active("len2_lc2", 1'b0);
      chk_noise("len0_noise", 4'd0);
      a_in = 2'd3; d_in = 8'h18; wr_in = 1'b1; lc_pulse_in = 1'b1; cyc();
      chk_active("load_beats_dec", 1'b1);
      lc(1); chk_active("load_then_lc1", 1'b1);
      lc(1); chk_active("load_then_lc2", 1'b0);
      wreg(2'd0, 8'h3F); wreg(2'd3, 8'h18);
      lc(3); chk_active("halt_holds", 1'b1);
      wreg(2'd0, 8'h1F);
      lc(1); chk_active("unhalt_lc1", 1'b1);
      lc(1); chk_active("unhalt_lc2", 1'b0);
      wreg(2'd3, 8'h00);
      lc(9); chk_active("len10_lc9", 1'b1);
      lc(1); chk_active("len10_lc10", 1'b0);
      wreg(2'd3, 8'hF8);
      lc(29); chk_active("len30_lc29", 1'b1);
      lc(1);  chk_active("len30_lc30", 1'b0);

      // Envelope: vol=1, loop; decay 15 then down every 2 ticks, wraps after 0
      wreg(2'd0, 8'h21); wreg(2'd3, 8'h08);
      chk_noise("env_before_tick", 4'd0);
      for (int n = 1; n <= 35; n++) begin
         eg_pulse_in = 1'b1; cyc();
         e = (n <= 32) ? 4'(15 - (n - 1) / 2) : 4'(15 - (n - 33) / 2);
         chk_noise($sformatf("env_n%0d", n), e);
      end

      // Mid-run reset clears timer and length
      rst_in = 1'b1; cyc();
      chk_active("midrst_active", 1'b0);
      chk_noise("midrst_noise", 4'd0);
      rst_in = 1'b0;
      wreg(2'd0, 8'h1F); wreg(2'd3, 8'h08);
      chk_noise("postrst_seed", 4'd0);
      apu(1); chk_noise("postrst_timer0_step", 4'd15);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
